// File: rtl/score_pkg.sv
// Shared constants for the score renderer: glyph geometry, the 4x7 digit font
// and small constant helpers used when sizing the datapath.
package score_pkg;

    localparam int GLYPH_W = 4;
    localparam int GLYPH_H = 7;

    // Row 0 occupies bits 27:24; inside each row nibble, column 0 is the MSB.
    localparam logic [27:0] GLYPH_TABLE [10] = '{
        28'b0110_1001_1001_1001_1001_1001_0110,
        28'b0010_0110_0010_0010_0010_0010_0111,
        28'b0110_1001_0001_0010_0100_1000_1111,
        28'b1110_0001_0001_0110_0001_0001_1110,
        28'b1001_1001_1001_1111_0001_0001_0001,
        28'b1111_1000_1110_0001_0001_1001_0110,
        28'b0110_1000_1000_1110_1001_1001_0110,
        28'b1111_0001_0010_0100_0100_0100_0100,
        28'b0110_1001_1001_0110_1001_1001_0110,
        28'b0110_1001_1001_0111_0001_0001_0110
    };

    function automatic logic glyph_bit(input logic [3:0] d, input logic [2:0] r, input logic [1:0] c);
        logic [4:0] idx;
        idx = {r, c};
        if (d > 4'd9 || r > 3'd6) return 1'b0;
        return GLYPH_TABLE[d][5'd27 - idx];
    endfunction

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per cycle after start,
// done is high for one cycle once all SCORE_W bits have been shifted in.
module bin2bcd_seq #(
    parameter int SCORE_W = 7,
    parameter int DIGITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   bits_left;

    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            bits_left <= '0;
            bin_r     <= '0;
            bcd_r     <= '0;
        end else if (start && !busy) begin
            busy      <= 1'b1;
            bits_left <= CNT_W'(SCORE_W);
            bin_r     <= bin;
            bcd_r     <= '0;
        end else if (busy) begin
            if (bits_left != '0) begin
                bcd_r     <= {bcd_adj[BCD_W-2:0], bin_r[SCORE_W-1]};
                bin_r     <= bin_r << 1;
                bits_left <= bits_left - CNT_W'(1);
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (bits_left == '0);
    assign bcd  = bcd_r;

endmodule

// File: rtl/score_renderer.sv
// Renders a decimal score as scaled 4x7 glyphs into a pixel stream, with
// frame-synchronous display updates and blinking after a value change.
module score_renderer
    import score_pkg::*;
#(
    parameter int SCORE_W      = 7,
    parameter int DIGITS       = 2,
    parameter int SCALE_LOG2   = 2,
    parameter int DIGIT_GAP    = 4,
    parameter int V_OFFSET     = 16,
    parameter int BLINK_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        x,
    input  logic [11:0]        y,
    input  logic [11:0]        h_offset,
    input  logic               frame_start,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic               score_ready,
    output logic               out
);

    localparam int          CELL      = 1 << SCALE_LOG2;
    localparam int          BOX_W     = GLYPH_W * CELL;
    localparam int          BOX_H     = GLYPH_H * CELL;
    localparam int          PITCH     = BOX_W + DIGIT_GAP;
    localparam int          BCD_W     = 4 * DIGITS;
    localparam int unsigned MAX_SCORE = pow10(DIGITS) - 1;
    localparam int          BLINK_W   = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

    logic [SCORE_W-1:0] score_sat;
    logic               conv_start;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [BCD_W-1:0]   pending;
    logic               pending_flag;
    logic [BCD_W-1:0]   shown;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_off;

    logic               hit_d;
    logic [3:0]         digit_d;
    logic [2:0]         row_d;
    logic [1:0]         col_d;
    logic               y_in;
    logic               lead_zero;
    logic [3:0]         digit_v;
    int                 px_left;

    logic               s1_hit;
    logic [3:0]         s1_digit;
    logic [2:0]         s1_row;
    logic [1:0]         s1_col;

    always_comb begin
        score_sat = score_in;
        if (32'(score_in) > MAX_SCORE) score_sat = SCORE_W'(MAX_SCORE);
    end

    assign conv_start = score_valid && score_ready && !conv_busy;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (score_sat),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          score_ready <= 1'b1;
        else if (conv_start) score_ready <= 1'b0;
        else if (conv_done)  score_ready <= 1'b1;
    end

    // A fresh result wins over clearing, so a result landing on frame_start stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            pending_flag <= 1'b0;
            shown        <= '0;
        end else begin
            if (frame_start && pending_flag) shown <= pending;
            if (conv_done) begin
                pending      <= conv_bcd;
                pending_flag <= 1'b1;
            end else if (frame_start) begin
                pending_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (frame_start) begin
            if (pending_flag && (pending != shown)) blink_cnt <= BLINK_W'(BLINK_FRAMES);
            else if (blink_cnt != '0)               blink_cnt <= blink_cnt - BLINK_W'(1);
        end
    end

    assign blink_off = (blink_cnt != '0) && blink_cnt[0];

    // Boxes never overlap, so at most one digit claims the pixel.
    always_comb begin
        hit_d     = 1'b0;
        digit_d   = 4'd0;
        row_d     = 3'd0;
        col_d     = 2'd0;
        lead_zero = 1'b1;
        digit_v   = 4'd0;
        px_left   = 0;
        y_in      = (int'(y) >= V_OFFSET) && (int'(y) < V_OFFSET + BOX_H);
        for (int k = 0; k < DIGITS; k++) begin
            digit_v   = shown[BCD_W-1-4*k -: 4];
            lead_zero = lead_zero && (digit_v == 4'd0);
            px_left   = int'(h_offset) + k * PITCH;
            if (y_in && (int'(x) >= px_left) && (int'(x) < px_left + BOX_W)
                && !(lead_zero && (k != DIGITS - 1))) begin
                hit_d   = 1'b1;
                digit_d = digit_v;
                col_d   = 2'((int'(x) - px_left) >> SCALE_LOG2);
                row_d   = 3'((int'(y) - V_OFFSET) >> SCALE_LOG2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit   <= 1'b0;
            s1_digit <= 4'd0;
            s1_row   <= 3'd0;
            s1_col   <= 2'd0;
            out      <= 1'b0;
        end else begin
            s1_hit   <= hit_d;
            s1_digit <= digit_d;
            s1_row   <= row_d;
            s1_col   <= col_d;
            out      <= s1_hit && !blink_off && glyph_bit(s1_digit, s1_row, s1_col);
        end
    end

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench for score_renderer: directed scenarios plus random scores,
// compared against a frame-level behavioural model of the display.
module tb_score_renderer;

    localparam int SCORE_W      = 7;
    localparam int DIGITS       = 2;
    localparam int SCALE_LOG2   = 2;
    localparam int DIGIT_GAP    = 4;
    localparam int V_OFFSET     = 16;
    localparam int BLINK_FRAMES = 8;
    localparam int CELL         = 1 << SCALE_LOG2;
    localparam int BOX_W        = 4 * CELL;
    localparam int BOX_H        = 7 * CELL;
    localparam int PITCH        = BOX_W + DIGIT_GAP;
    localparam int MAX_VAL      = 99;

    localparam bit [3:0] GLYPH [10][7] = '{
        '{4'b0110, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0110},
        '{4'b0010, 4'b0110, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0111},
        '{4'b0110, 4'b1001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111},
        '{4'b1110, 4'b0001, 4'b0001, 4'b0110, 4'b0001, 4'b0001, 4'b1110},
        '{4'b1001, 4'b1001, 4'b1001, 4'b1111, 4'b0001, 4'b0001, 4'b0001},
        '{4'b1111, 4'b1000, 4'b1110, 4'b0001, 4'b0001, 4'b1001, 4'b0110},
        '{4'b0110, 4'b1000, 4'b1000, 4'b1110, 4'b1001, 4'b1001, 4'b0110},
        '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100},
        '{4'b0110, 4'b1001, 4'b1001, 4'b0110, 4'b1001, 4'b1001, 4'b0110},
        '{4'b0110, 4'b1001, 4'b1001, 4'b0111, 4'b0001, 4'b0001, 4'b0110}
    };

    logic               clk = 1'b0;
    logic               rst_n;
    logic [11:0]        x;
    logic [11:0]        y;
    logic [11:0]        h_offset;
    logic               frame_start;
    logic [SCORE_W-1:0] score_in;
    logic               score_valid;
    logic               score_ready;
    logic               out;

    int total = 0;
    int bad   = 0;

    int m_disp;
    int m_pend;
    bit m_pend_flag;
    int m_blink;

    score_renderer #(
        .SCORE_W      (SCORE_W),
        .DIGITS       (DIGITS),
        .SCALE_LOG2   (SCALE_LOG2),
        .DIGIT_GAP    (DIGIT_GAP),
        .V_OFFSET     (V_OFFSET),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .h_offset    (h_offset),
        .frame_start (frame_start),
        .score_in    (score_in),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .out         (out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    function automatic int satScore(input int s);
        return (s > MAX_VAL) ? MAX_VAL : s;
    endfunction

    function automatic logic modelPixel(input int px, input int py);
        int left;
        int pw;
        int d;
        if (m_blink % 2 == 1) return 1'b0;
        if (py < V_OFFSET || py >= V_OFFSET + BOX_H) return 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            left = int'(h_offset) + k * PITCH;
            if (px >= left && px < left + BOX_W) begin
                pw = 1;
                for (int j = 0; j < DIGITS - 1 - k; j++) pw = pw * 10;
                if (k != DIGITS - 1 && m_disp < pw) return 1'b0;
                d = (m_disp / pw) % 10;
                return GLYPH[d][(py - V_OFFSET) / CELL][3 - (px - left) / CELL];
            end
        end
        return 1'b0;
    endfunction

    function automatic void modelFrame();
        if (m_pend_flag) begin
            if (m_pend != m_disp)  m_blink = BLINK_FRAMES;
            else if (m_blink > 0)  m_blink--;
            m_disp      = m_pend;
            m_pend_flag = 1'b0;
        end else if (m_blink > 0) begin
            m_blink--;
        end
    endfunction

    function automatic void modelReset();
        m_disp      = 0;
        m_pend      = 0;
        m_pend_flag = 1'b0;
        m_blink     = 0;
    endfunction

    task automatic pulseFrame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        modelFrame();
    endtask

    // Offer one score and follow score_ready through the whole conversion.
    task automatic applyStimulus(input int score, input bit frame_at_done);
        checkOutput("ready_idle", score_ready, 1'b1);
        score_in    = SCORE_W'(score);
        score_valid = 1'b1;
        @(posedge clk); #1;
        score_valid = 1'b0;
        score_in    = SCORE_W'($urandom);
        checkOutput("ready_drop", score_ready, 1'b0);
        for (int i = 1; i <= SCORE_W; i++) begin
            @(posedge clk); #1;
            checkOutput("ready_busy", score_ready, 1'b0);
        end
        if (frame_at_done) frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        if (frame_at_done) modelFrame();
        m_pend      = satScore(score);
        m_pend_flag = 1'b1;
        checkOutput("ready_back", score_ready, 1'b1);
    endtask

    // Streams one pixel per cycle; out is compared two cycles after presentation.
    task automatic scanPixels(input string tag, input int x0, input int x1,
                              input int y0, input int y1, input int step);
        logic pipe0;
        logic pipe1;
        int   n;
        pipe0 = 1'b0;
        pipe1 = 1'b0;
        n     = 0;
        for (int yy = y0; yy <= y1; yy += step) begin
            for (int xx = x0; xx <= x1; xx += step) begin
                x     = 12'(xx);
                y     = 12'(yy);
                pipe1 = pipe0;
                pipe0 = modelPixel(xx, yy);
                @(posedge clk); #1;
                n++;
                if (n >= 2) checkOutput(tag, out, pipe1);
            end
        end
        @(posedge clk); #1;
        checkOutput(tag, out, pipe0);
    endtask

    initial begin
        int sc;
        int hx;
        rst_n       = 1'b0;
        x           = '0;
        y           = '0;
        h_offset    = 12'd100;
        frame_start = 1'b0;
        score_in    = '0;
        score_valid = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", score_ready, 1'b1);
        checkOutput("reset_out", out, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] idle display after reset");
        pulseFrame();
        scanPixels("idle_zero", 98, 140, V_OFFSET, V_OFFSET + 27, 1);

        $display("[TB] score 42 with blinking");
        scanPixels("pre42_partial", 98, 140, V_OFFSET, V_OFFSET + 6, 2);
        applyStimulus(42, 1'b0);
        scanPixels("hold_until_frame", 98, 140, V_OFFSET - 1, V_OFFSET + BOX_H, 2);
        for (int f = 0; f < 10; f++) begin
            pulseFrame();
            scanPixels("blink42", 98, 140, V_OFFSET - 1, V_OFFSET + BOX_H, 2);
        end

        $display("[TB] saturation of 127");
        applyStimulus(127, 1'b0);
        pulseFrame();
        scanPixels("sat99", 98, 140, V_OFFSET, V_OFFSET + 27, 2);

        $display("[TB] newer result overwrites pending");
        applyStimulus(5, 1'b0);
        applyStimulus(6, 1'b0);
        pulseFrame();
        scanPixels("overwrite6", 98, 140, V_OFFSET, V_OFFSET + 27, 1);

        $display("[TB] completion coincident with frame_start");
        applyStimulus(33, 1'b1);
        scanPixels("coincident_hold", 98, 140, V_OFFSET, V_OFFSET + 27, 2);
        pulseFrame();
        scanPixels("coincident_apply", 98, 140, V_OFFSET, V_OFFSET + 27, 2);
        repeat (8) pulseFrame();
        scanPixels("steady33", 114, 124, V_OFFSET, V_OFFSET + 3, 1);
        x = h_offset + 12'd20;
        y = 12'(V_OFFSET);
        @(posedge clk); #1;
        x = h_offset + 12'd16;
        @(posedge clk); #1;
        checkOutput("latency_cell00", out, modelPixel(int'(h_offset) + 20, V_OFFSET));
        @(posedge clk); #1;
        checkOutput("latency_gap", out, 1'b0);

        $display("[TB] same value reapplied keeps blink state");
        applyStimulus(33, 1'b0);
        pulseFrame();
        scanPixels("same33", 98, 140, V_OFFSET, V_OFFSET + 27, 2);

        $display("[TB] reset during conversion");
        score_in    = SCORE_W'(42);
        score_valid = 1'b1;
        @(posedge clk); #1;
        score_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", score_ready, 1'b1);
        checkOutput("abort_out", out, 1'b0);
        modelReset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_ready_idle", score_ready, 1'b1);
        pulseFrame();
        scanPixels("abort_display", 98, 140, V_OFFSET, V_OFFSET + 27, 1);

        $display("[TB] random scores and positions");
        for (int it = 0; it < 6; it++) begin
            h_offset = (it == 5) ? 12'd4085 : 12'($urandom_range(0, 3900));
            sc = int'($urandom_range(0, 127));
            applyStimulus(sc, 1'b0);
            if ($urandom_range(0, 1) == 1) applyStimulus(int'($urandom_range(0, 127)), 1'b0);
            hx = int'(h_offset) + 2 * PITCH + 2;
            if (hx > 4095) hx = 4095;
            for (int f = 0; f < 2; f++) begin
                pulseFrame();
                scanPixels("rand_px", int'(h_offset) - 2, hx, V_OFFSET - 1, V_OFFSET + BOX_H, 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_renderer.md
SCORE_RENDERER -- requirements
Module: score_renderer

Interface
REQ-001 Parameter SCORE_W, default 7, score input width in bits (1..14).
REQ-002 Parameter DIGITS, default 2, number of decimal digits rendered (1..4).
REQ-003 Parameter SCALE_LOG2, default 2, glyph cell size is 2^SCALE_LOG2 pixels square.
REQ-004 Parameter DIGIT_GAP, default 4, blank pixels between adjacent digits.
REQ-005 Parameter V_OFFSET, default 16, top pixel row of the digit band.
REQ-006 Parameter BLINK_FRAMES, default 8, frames of blinking after a displayed score change; 0 disables blinking.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 x  input  12  current pixel column.
REQ-010 y  input  12  current pixel row.
REQ-011 h_offset  input  12  left pixel column of the most-significant digit.
REQ-012 frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-013 score_in  input  SCORE_W  binary score value.
REQ-014 score_valid  input  1  score_in is valid.
REQ-015 score_ready  output  1  block can accept a score.
REQ-016 out  output  1  1 when the pixel presented two cycles earlier is lit.

Function
REQ-017 A score is accepted on a cycle with score_valid and score_ready both high; score_ready is registered and deasserts the cycle after acceptance.
REQ-018 Accepted scores above 10^DIGITS-1 saturate to all nines before conversion.
REQ-019 Conversion is sequential double-dabble, one bit per cycle; score_ready reasserts exactly SCORE_W+1 cycles after acceptance.
REQ-020 The conversion result is written to a pending register with a pending flag; a newer result overwrites an unapplied one.
REQ-021 On frame_start with the pending flag set, the pending digits move to the displayed register and the pending flag clears; displayed digits never change at any other time.
REQ-022 A conversion completing on the same cycle as frame_start becomes pending and is applied at the next frame_start.
REQ-023 When applied digits differ from the previously displayed digits, blink_cnt loads BLINK_FRAMES; otherwise blink_cnt is unchanged.
REQ-024 blink_cnt decrements on each frame_start while nonzero; out is forced 0 while blink_cnt is nonzero and its bit 0 is 1.
REQ-025 Digit k (k=0 most significant) occupies x in [h_offset + k*(4*2^SCALE_LOG2 + DIGIT_GAP), that + 4*2^SCALE_LOG2) and y in [V_OFFSET, V_OFFSET + 7*2^SCALE_LOG2).
REQ-026 Glyph cell column = (x - digit left edge) >> SCALE_LOG2 (0..3); row = (y - V_OFFSET) >> SCALE_LOG2 (0..6); the pixel is lit if the glyph table bit for (digit value, row, column) is 1.
REQ-027 Leading-zero suppression: a digit renders blank when it and all more-significant digits are zero; the least-significant digit always renders.
REQ-028 Pixel path is two registered stages: stage 1 range compare, digit select, cell indices; stage 2 glyph lookup and blink mask into out.
REQ-029 Pixels outside every digit box produce out=0; comparisons are unsigned 12-bit with no wrap (boxes extending past 4095 are truncated).

Reset
REQ-030 While rst_n is low: out=0, score_ready=1, displayed digits all zero (renders "0"), pending flag clear, blink_cnt=0, pipeline stages cleared.
REQ-031 Reset asserted mid-conversion aborts it; no result becomes pending.

Structure
REQ-032 Package score_pkg holds GLYPH_W=4, GLYPH_H=7, and the constant glyph table for digits 0..9 (7 rows x 4 bits each).
REQ-033 Sequential converter is a sub-module bin2bcd_seq (start/busy/done, parametrised by SCORE_W and DIGITS), instantiated once.

Verification
REQ-034 Reset release, no score: frame rows V_OFFSET..V_OFFSET+27 at defaults -> only the least-significant digit box lit, pattern glyph "0"; MS digit blank.
REQ-035 Accept score 42 mid-frame -> score_ready low for 8 cycles; display stays "0" until next frame_start; then "42", blanked on alternate frames for 8 frames, steady afterwards.
REQ-036 Accept score 127 with DIGITS=2 -> displays "99".
REQ-037 Accept 5 then 6 before any frame_start -> next frame shows "6"; "5" never appears.
REQ-038 Pixel at x=h_offset+20, y=V_OFFSET presented at cycle t -> out reflects glyph cell (row 0, column 0) of digit 1 at cycle t+2; x=h_offset+16 -> out=0 (gap).
REQ-039 rst_n pulsed low 3 cycles after acceptance of 42 -> score_ready=1 immediately, display remains "0" after following frame_start.
